// File: rtl/alu_wb_seq_pkg.sv
// Shared types and constants for the ALU Wishbone sequencer.
package alu_wb_seq_pkg;

   localparam int unsigned DATA_W      = 8;
   localparam int unsigned ADDR_W      = 4;
   localparam int unsigned CNT_W       = 4;
   localparam int unsigned TIMEOUT_DEF = 15;

   localparam logic [ADDR_W-1:0] REG_A     = 4'h0;
   localparam logic [ADDR_W-1:0] REG_B     = 4'h1;
   localparam logic [ADDR_W-1:0] REG_OP    = 4'h2;
   localparam logic [ADDR_W-1:0] REG_OUT   = 4'h3;
   localparam logic [ADDR_W-1:0] REG_FLAGS = 4'h4;

   typedef enum logic [2:0] {
      IDLE,
      WR_A,
      WR_B,
      WR_OP,
      RD_OUT,
      RD_FLG,
      RESP
   } state_e;

   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [DATA_W-1:0] op;
   } job_t;

   // Bus address driven during each phase.
   function automatic logic [ADDR_W-1:0] phase_addr(input state_e s);
      logic [ADDR_W-1:0] addr;
      case (s)
         WR_A:    addr = REG_A;
         WR_B:    addr = REG_B;
         WR_OP:   addr = REG_OP;
         RD_OUT:  addr = REG_OUT;
         RD_FLG:  addr = REG_FLAGS;
         default: addr = REG_A;
      endcase
      return addr;
   endfunction

endpackage

// File: rtl/alu_wb_seq_rr_arb.sv
// Two-way round-robin arbiter; remembers which requester won last.
module alu_wb_seq_rr_arb (
   input  logic       i_clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       en,
   output logic [1:0] gnt_c
);

   logic last_q;   // 1: requester 1 was granted last

   // Grant selection: a tie goes to the requester not served last.
   always_comb begin
      gnt_c = 2'b00;
      case (req)
         2'b01:   gnt_c = 2'b01;
         2'b10:   gnt_c = 2'b10;
         2'b11:   gnt_c = last_q ? 2'b01 : 2'b10;
         default: gnt_c = 2'b00;
      endcase
   end

   // Pointer update; reset value lets requester 0 win the first tie.
   always_ff @(posedge i_clk) begin
      if (!reset)  last_q <= 1'b1;
      else if (en) last_q <= gnt_c[1];
   end

endmodule

// File: rtl/alu_wb_seq.sv
// Sequences requester jobs onto a pipelined Wishbone ALU: write A/B/OP, read OUT/FLAGS.
module alu_wb_seq
   import alu_wb_seq_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEF,
   parameter int unsigned NREQ    = 2
) (
   input  logic                   i_clk,
   input  logic                   reset,
   input  logic [NREQ-1:0]        i_req_valid,
   input  logic [DATA_W*NREQ-1:0] i_req_a,
   input  logic [DATA_W*NREQ-1:0] i_req_b,
   input  logic [DATA_W*NREQ-1:0] i_req_op,
   output logic [NREQ-1:0]        o_req_ready,
   output logic [NREQ-1:0]        o_rsp_valid,
   input  logic [NREQ-1:0]        i_rsp_ready,
   output logic [DATA_W-1:0]      o_rsp_out,
   output logic [DATA_W-1:0]      o_rsp_flags,
   output logic                   o_rsp_err,
   output logic                   o_wb_cyc,
   output logic                   o_wb_stb,
   output logic                   o_wb_we,
   output logic [ADDR_W-1:0]      o_wb_addr,
   output logic [DATA_W-1:0]      o_wb_data,
   input  logic                   i_wb_ack,
   input  logic                   i_wb_stall,
   input  logic [DATA_W-1:0]      i_wb_data
);

   state_e             state_q, state_d;
   job_t               job_q, job_d;
   logic [NREQ-1:0]    gnt_q, gnt_d, arb_gnt_c;
   logic [DATA_W-1:0]  out_q, out_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [NREQ-1:0]    req_ready_d, rsp_valid_d;
   logic [DATA_W-1:0]  rsp_out_d, rsp_flags_d, wb_data_d;
   logic [ADDR_W-1:0]  wb_addr_d;
   logic               rsp_err_d, wb_cyc_d, wb_stb_d, wb_we_d;

   logic               is_phase_c, take_c, ack_ok_c, tick_c, tmo_c;

   // Phase bookkeeping: an ack only counts once the strobe has been accepted.
   assign is_phase_c = (state_q inside {WR_A, WR_B, WR_OP, RD_OUT, RD_FLG});
   assign take_c     = (state_q == IDLE) && (o_req_ready == '0) && (i_req_valid != '0);
   assign ack_ok_c   = is_phase_c && !o_wb_stb && i_wb_ack;
   assign tick_c     = is_phase_c && (!o_wb_stb || i_wb_stall) && !ack_ok_c;
   assign tmo_c      = tick_c && (cnt_q == CNT_W'(TIMEOUT - 1));

   alu_wb_seq_rr_arb u_arb (
      .i_clk (i_clk),
      .reset (reset),
      .req   (i_req_valid),
      .en    (take_c),
      .gnt_c (arb_gnt_c)
   );

   // State register.
   always_ff @(posedge i_clk) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:   if (o_req_ready != '0) state_d = WR_A;
         WR_A:   if (tmo_c) state_d = RESP; else if (ack_ok_c) state_d = WR_B;
         WR_B:   if (tmo_c) state_d = RESP; else if (ack_ok_c) state_d = WR_OP;
         WR_OP:  if (tmo_c) state_d = RESP; else if (ack_ok_c) state_d = RD_OUT;
         RD_OUT: if (tmo_c) state_d = RESP; else if (ack_ok_c) state_d = RD_FLG;
         RD_FLG: if (tmo_c || ack_ok_c) state_d = RESP;
         RESP:   if ((i_rsp_ready & gnt_q) != '0) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Next values of the registered outputs and job datapath.
   always_comb begin
      req_ready_d = '0;
      rsp_valid_d = o_rsp_valid;
      rsp_out_d   = o_rsp_out;
      rsp_flags_d = o_rsp_flags;
      rsp_err_d   = o_rsp_err;
      wb_cyc_d    = o_wb_cyc;
      wb_stb_d    = o_wb_stb;
      wb_we_d     = o_wb_we;
      wb_addr_d   = o_wb_addr;
      wb_data_d   = o_wb_data;
      job_d       = job_q;
      gnt_d       = gnt_q;
      out_d       = out_q;
      cnt_d       = cnt_q;

      if (take_c) begin
         req_ready_d = arb_gnt_c;
         gnt_d       = arb_gnt_c;
         if (arb_gnt_c[1]) job_d = '{a: i_req_a[DATA_W +: DATA_W], b: i_req_b[DATA_W +: DATA_W],
                                     op: i_req_op[DATA_W +: DATA_W]};
         else              job_d = '{a: i_req_a[0 +: DATA_W], b: i_req_b[0 +: DATA_W],
                                     op: i_req_op[0 +: DATA_W]};
      end

      if (is_phase_c) begin
         if (o_wb_stb && !i_wb_stall) wb_stb_d = 1'b0;
         if (tick_c && !tmo_c)        cnt_d    = cnt_q + CNT_W'(1);
         if (ack_ok_c && (state_q == RD_OUT)) out_d = i_wb_data;
      end

      if (state_d != state_q) begin
         case (state_d)
            WR_A, WR_B, WR_OP, RD_OUT, RD_FLG: begin
               wb_cyc_d  = 1'b1;
               wb_stb_d  = 1'b1;
               cnt_d     = '0;
               wb_addr_d = phase_addr(state_d);
               wb_we_d   = (state_d inside {WR_A, WR_B, WR_OP});
               case (state_d)
                  WR_A:    wb_data_d = job_q.a;
                  WR_B:    wb_data_d = job_q.b;
                  WR_OP:   wb_data_d = job_q.op;
                  default: wb_data_d = '0;
               endcase
            end
            RESP: begin
               wb_cyc_d    = 1'b0;
               wb_stb_d    = 1'b0;
               wb_we_d     = 1'b0;
               cnt_d       = '0;
               rsp_valid_d = gnt_q;
               rsp_err_d   = tmo_c;
               rsp_out_d   = tmo_c ? '0 : out_q;
               rsp_flags_d = tmo_c ? '0 : i_wb_data;
            end
            default: rsp_valid_d = '0;
         endcase
      end
   end

   // Output and datapath registers.
   always_ff @(posedge i_clk) begin
      if (!reset) begin
         o_req_ready <= '0;
         o_rsp_valid <= '0;
         o_rsp_out   <= '0;
         o_rsp_flags <= '0;
         o_rsp_err   <= 1'b0;
         o_wb_cyc    <= 1'b0;
         o_wb_stb    <= 1'b0;
         o_wb_we     <= 1'b0;
         o_wb_addr   <= '0;
         o_wb_data   <= '0;
         job_q       <= '0;
         gnt_q       <= '0;
         out_q       <= '0;
         cnt_q       <= '0;
      end else begin
         o_req_ready <= req_ready_d;
         o_rsp_valid <= rsp_valid_d;
         o_rsp_out   <= rsp_out_d;
         o_rsp_flags <= rsp_flags_d;
         o_rsp_err   <= rsp_err_d;
         o_wb_cyc    <= wb_cyc_d;
         o_wb_stb    <= wb_stb_d;
         o_wb_we     <= wb_we_d;
         o_wb_addr   <= wb_addr_d;
         o_wb_data   <= wb_data_d;
         job_q       <= job_d;
         gnt_q       <= gnt_d;
         out_q       <= out_d;
         cnt_q       <= cnt_d;
      end
   end

endmodule

// File: tb/tb_alu_wb_seq.sv
// Directed bench for alu_wb_seq with a small pipelined Wishbone slave model.
module tb_alu_wb_seq;
   import alu_wb_seq_pkg::*;

   logic        i_clk = 1'b0;
   logic        reset;
   logic [1:0]  i_req_valid;
   logic [15:0] i_req_a, i_req_b, i_req_op;
   logic [1:0]  o_req_ready, o_rsp_valid, i_rsp_ready;
   logic [7:0]  o_rsp_out, o_rsp_flags;
   logic        o_rsp_err;
   logic        o_wb_cyc, o_wb_stb, o_wb_we;
   logic [3:0]  o_wb_addr;
   logic [7:0]  o_wb_data;
   logic        i_wb_ack, i_wb_stall;
   logic [7:0]  i_wb_data;

   always #5 i_clk = ~i_clk;

   alu_wb_seq dut (
      .i_clk       (i_clk),
      .reset       (reset),
      .i_req_valid (i_req_valid),
      .i_req_a     (i_req_a),
      .i_req_b     (i_req_b),
      .i_req_op    (i_req_op),
      .o_req_ready (o_req_ready),
      .o_rsp_valid (o_rsp_valid),
      .i_rsp_ready (i_rsp_ready),
      .o_rsp_out   (o_rsp_out),
      .o_rsp_flags (o_rsp_flags),
      .o_rsp_err   (o_rsp_err),
      .o_wb_cyc    (o_wb_cyc),
      .o_wb_stb    (o_wb_stb),
      .o_wb_we     (o_wb_we),
      .o_wb_addr   (o_wb_addr),
      .o_wb_data   (o_wb_data),
      .i_wb_ack    (i_wb_ack),
      .i_wb_stall  (i_wb_stall),
      .i_wb_data   (i_wb_data)
   );

   // Slave configuration, written only by the stimulus process.
   logic [7:0] cfg_out = 8'h00, cfg_flg = 8'h00;
   logic [3:0] cfg_st_addr = 4'h0, cfg_na_addr = 4'h0;
   int         cfg_st_n = 0;
   logic       cfg_na_en = 1'b0;
   logic       stray_ack = 1'b0;

   // Slave state and accepted-transfer log.
   logic       s_ack = 1'b0;
   logic [7:0] s_rdata = 8'h00;
   int         stall_done = 0;
   int         log_n = 0;
   logic       lg_we   [0:511];
   logic [3:0] lg_addr [0:511];
   logic [7:0] lg_data [0:511];
   int         cyc_n = 0;

   assign i_wb_stall = o_wb_cyc && o_wb_stb && (o_wb_addr == cfg_st_addr) && (stall_done < cfg_st_n);
   assign i_wb_ack   = s_ack | stray_ack;
   assign i_wb_data  = s_rdata;

   always @(posedge i_clk) cyc_n <= cyc_n + 1;

   // Slave: acks one cycle after accepting a strobe, returns OUT/FLAGS on reads.
   always @(posedge i_clk) begin
      s_ack <= 1'b0;
      if (!o_wb_cyc)       stall_done <= 0;
      else if (i_wb_stall) stall_done <= stall_done + 1;
      if (o_wb_cyc && o_wb_stb && !i_wb_stall) begin
         if (log_n < 512) begin
            lg_we[log_n]   <= o_wb_we;
            lg_addr[log_n] <= o_wb_addr;
            lg_data[log_n] <= o_wb_data;
            log_n          <= log_n + 1;
         end
         if (!(cfg_na_en && (o_wb_addr == cfg_na_addr))) begin
            s_ack   <= 1'b1;
            s_rdata <= (o_wb_addr == REG_OUT) ? cfg_out : (o_wb_addr == REG_FLAGS) ? cfg_flg : 8'h00;
         end
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
      end
   endtask

   task automatic fail_wait(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: wait bound expired (cycle %0d)", nm, cyc_n);
   endtask

   typedef struct {
      int         r;
      logic [7:0] a, b, op, s_out, s_flg;
      logic [3:0] st_addr;
      int         st_n;
      logic       na_en;
      logic [3:0] na_addr;
      int         lat;
      logic       err;
      logic [7:0] e_out, e_flg;
   } vec_t;

   vec_t vecs[7];

   // Caller is at a negedge; returns at the negedge where the ready pulse is seen.
   task automatic issue(input int r, input logic [7:0] a, b, op, output int t0);
      i_req_a[8*r +: 8]  = a;
      i_req_b[8*r +: 8]  = b;
      i_req_op[8*r +: 8] = op;
      i_req_valid[r]     = 1'b1;
      t0 = -1;
      for (int k = 0; k < 200; k++) begin
         @(negedge i_clk);
         if (o_req_ready[r]) begin
            t0 = cyc_n;
            break;
         end
      end
      i_req_valid[r] = 1'b0;
      if (t0 < 0) fail_wait("req_ready");
   endtask

   task automatic await_rsp(input int r, input int t0, output int lat);
      lat = -1;
      for (int k = 0; k < 300; k++) begin
         @(negedge i_clk);
         if (o_rsp_valid[r]) begin
            lat = cyc_n - t0;
            break;
         end
      end
      if (lat < 0) fail_wait("rsp_valid");
   endtask

   task automatic rel(input int r);
      i_rsp_ready[r] = 1'b1;
      @(negedge i_clk);
      i_rsp_ready[r] = 1'b0;
      chk("rsp_drop", 32'(o_rsp_valid), 32'h0);
   endtask

   task automatic run_vec(input vec_t v);
      int t0, lat, base;
      logic [1:0] exp_v;
      cfg_out = v.s_out;  cfg_flg = v.s_flg;
      cfg_st_addr = v.st_addr;  cfg_st_n = v.st_n;
      cfg_na_en = v.na_en;  cfg_na_addr = v.na_addr;
      base = log_n;
      issue(v.r, v.a, v.b, v.op, t0);
      if (t0 < 0) return;
      await_rsp(v.r, t0, lat);
      if (lat < 0) return;
      exp_v = (v.r == 1) ? 2'b10 : 2'b01;
      chk("latency",   32'(lat),         32'(v.lat));
      chk("rsp_valid", 32'(o_rsp_valid), 32'(exp_v));
      chk("rsp_out",   32'(o_rsp_out),   32'(v.e_out));
      chk("rsp_flags", 32'(o_rsp_flags), 32'(v.e_flg));
      chk("rsp_err",   32'(o_rsp_err),   32'(v.err));
      chk("cyc_idle",  32'({o_wb_cyc, o_wb_stb}), 32'h0);
      if (!v.err) begin
         chk("log_len", 32'(log_n - base), 32'd5);
         if (log_n - base == 5) begin
            for (int i = 0; i < 5; i++) begin
               chk("log_we",   32'(lg_we[base+i]),   32'(i < 3));
               chk("log_addr", 32'(lg_addr[base+i]), 32'(i));
            end
            chk("log_data_a",  32'(lg_data[base]),   32'(v.a));
            chk("log_data_b",  32'(lg_data[base+1]), 32'(v.b));
            chk("log_data_op", 32'(lg_data[base+2]), 32'(v.op));
         end
      end
      rel(v.r);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, lat, found, seen;
      logic [1:0] got;
      vec_t v;

      //            r  a      b      op     s_out  s_flg  st_a  st_n na    na_a  lat err e_out  e_flg
      vecs[0] = '{0, 8'h12, 8'h34, 8'h01, 8'h46, 8'h00, 4'h0, 0,  1'b0, 4'h0, 11, 1'b0, 8'h46, 8'h00};
      vecs[1] = '{1, 8'hff, 8'h01, 8'h01, 8'h00, 8'h03, 4'h0, 0,  1'b0, 4'h0, 11, 1'b0, 8'h00, 8'h03};
      vecs[2] = '{0, 8'ha5, 8'h5a, 8'h02, 8'h55, 8'h80, 4'h1, 3,  1'b0, 4'h0, 14, 1'b0, 8'h55, 8'h80};
      vecs[3] = '{1, 8'h0f, 8'hf0, 8'h03, 8'h77, 8'h11, 4'h0, 0,  1'b1, 4'h3, 23, 1'b1, 8'h00, 8'h00};
      vecs[4] = '{0, 8'h80, 8'h80, 8'h01, 8'h00, 8'h05, 4'h4, 2,  1'b0, 4'h0, 13, 1'b0, 8'h00, 8'h05};
      vecs[5] = '{1, 8'h01, 8'h02, 8'h01, 8'h03, 8'h00, 4'h0, 14, 1'b0, 4'h0, 25, 1'b0, 8'h03, 8'h00};
      vecs[6] = '{0, 8'h03, 8'h04, 8'h01, 8'haa, 8'hbb, 4'h0, 15, 1'b0, 4'h0, 16, 1'b1, 8'h00, 8'h00};

      reset = 1'b0;
      i_req_valid = 2'b00;  i_rsp_ready = 2'b00;
      i_req_a = 16'h0;  i_req_b = 16'h0;  i_req_op = 16'h0;
      repeat (3) @(negedge i_clk);
      chk("rst_wb_ctl",  32'({o_wb_cyc, o_wb_stb, o_wb_we}), 32'h0);
      chk("rst_wb_bus",  32'({o_wb_addr, o_wb_data}), 32'h0);
      chk("rst_req_rsp", 32'({o_req_ready, o_rsp_valid, o_rsp_err}), 32'h0);
      chk("rst_rsp_dat", 32'({o_rsp_out, o_rsp_flags}), 32'h0);
      reset = 1'b1;
      @(negedge i_clk);

      for (int i = 0; i < 7; i++) run_vec(vecs[i]);

      // Round-robin with both requesters held valid; fresh reset so requester 0 wins first.
      reset = 1'b0;
      repeat (2) @(negedge i_clk);
      reset = 1'b1;
      cfg_st_n = 0;  cfg_na_en = 1'b0;  cfg_out = 8'h5a;  cfg_flg = 8'h01;
      i_req_a = 16'h0201;  i_req_b = 16'h0403;  i_req_op = 16'h0101;
      i_req_valid = 2'b11;
      for (int j = 0; j < 4; j++) begin
         got = 2'b00;
         for (int k = 0; k < 100; k++) begin
            @(negedge i_clk);
            if (o_req_ready != 2'b00) begin
               got = o_req_ready;
               t0  = cyc_n;
               break;
            end
         end
         chk("rr_grant", 32'(got), (j % 2 == 1) ? 32'h2 : 32'h1);
         if (got == 2'b00) break;
         await_rsp(got[1] ? 1 : 0, t0, lat);
         chk("rr_latency", 32'(lat), 32'd11);
         chk("rr_rsp_bit", 32'(o_rsp_valid), 32'(got));
         if (j == 3) i_req_valid = 2'b00;
         rel(got[1] ? 1 : 0);
         i_req_valid = (j == 3) ? 2'b00 : 2'b11;
      end

      // Response held off while requester 1 waits: outputs frozen, no new grant.
      cfg_out = 8'h3c;  cfg_flg = 8'h10;
      issue(0, 8'h11, 8'h22, 8'h01, t0);
      await_rsp(0, t0, lat);
      chk("hold_latency", 32'(lat), 32'd11);
      i_req_a[15:8] = 8'h21;  i_req_b[15:8] = 8'h43;  i_req_op[15:8] = 8'h01;
      i_req_valid[1] = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge i_clk);
         chk("hold_state", 32'({o_rsp_valid, o_req_ready, o_wb_cyc, o_rsp_err, o_rsp_out, o_rsp_flags}),
             32'({2'b01, 2'b00, 1'b0, 1'b0, 8'h3c, 8'h10}));
      end
      rel(0);
      issue(1, 8'h21, 8'h43, 8'h01, t0);
      await_rsp(1, t0, lat);
      chk("hold_next_lat", 32'(lat), 32'd11);
      rel(1);

      // Reset during WR_OP drops the bus and discards the job; stray ack in IDLE is ignored.
      issue(1, 8'h99, 8'h88, 8'h02, t0);
      found = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge i_clk);
         if (o_wb_stb && (o_wb_addr == REG_OP)) begin
            found = 1;
            break;
         end
      end
      chk("reach_wr_op", 32'(found), 32'd1);
      reset = 1'b0;
      @(negedge i_clk);
      chk("rst_mid_drop", 32'({o_wb_cyc, o_wb_stb, o_rsp_valid, o_req_ready}), 32'h0);
      reset = 1'b1;
      seen = 0;
      for (int k = 0; k < 20; k++) begin
         stray_ack = (k == 5);
         @(negedge i_clk);
         if (o_rsp_valid != 2'b00 || o_wb_cyc) seen = 1;
      end
      stray_ack = 1'b0;
      chk("rst_no_rsp", 32'(seen), 32'd0);
      v = vecs[0];
      run_vec(v);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
